// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-window target.
package i2c_pkg;

  // Protocol FSM states.
  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  // SDA level of the acknowledge bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad input, with single-cycle
// rise/fall pulses derived from the synchronised level.
module i2c_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] synchronise; [2] holds the previous synchronised level.
  logic [2:0] sync_q;

  // Shift the pad sample through the synchroniser and edge-history flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {3{RESET_VAL}};
    else          sync_q <= {sync_q[1:0], d_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  =  sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/i2c_slave_regs.sv
// Oversampled I2C target exposing a register window through a write strobe
// and a combinational read-fetch port, with an auto-incrementing pointer.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010100,
  parameter int         NUM_REGS   = 16,
  parameter int         PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             valid_address,
  output logic             busy,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  // Bus idles high, so the synchronisers reset to 1 to avoid false edges.
  i2c_sync_edge #(.RESET_VAL(1'b1)) u_scl_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge #(.RESET_VAL(1'b1)) u_sda_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_t       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ack_phase_q, ack_phase_d;
  logic             rw_q, rw_d;
  logic             sda_oe_q, sda_oe_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;

  logic [7:0] byte_in;
  assign byte_in = {shift_q[6:0], sda_lvl};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REGS - 1)) return '0;
    else                           return p + 1'b1;
  endfunction

  // Protocol state register and registered bus/host outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      ack_phase_q <= ack_phase_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next-state decode: START/STOP override everything, then per-state
  // bit sampling on SCL rise and SDA drive changes on SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    ack_phase_d = ack_phase_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                valid_d     = 1'b1;
                busy_d      = 1'b1;
                rw_d        = byte_in[0];
                ack_phase_d = 1'b0;
                state_d     = ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = WAIT_STOP;
              end
            end
          end
        end

        // First SCL fall drives ACK; the second ends the ACK slot.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = ~I2C_ACK;
              ack_phase_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              bit_cnt_d   = '0;
              if (rw_q) begin
                shift_d  = rd_data;
                sda_oe_d = ~rd_data[7];
                ptr_d    = ptr_inc(ptr_q);
                state_d  = RD_DATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = PTR;
              end
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                ptr_d       = byte_in[PTR_W-1:0];
                ack_phase_d = 1'b0;
                state_d     = PTR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end

        PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = ~I2C_ACK;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              bit_cnt_d   = '0;
              state_d     = WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              wr_en_d     = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = byte_in;
              ptr_d       = ptr_inc(ptr_q);
              ack_phase_d = 1'b0;
              state_d     = WR_ACK;
            end
          end
        end

        // Byte stays unshifted in shift_q; bit_cnt selects the bit to drive.
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              state_d     = RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[3'(4'd7 - bit_cnt_q)];
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              ack_phase_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && ack_phase_q) begin
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            shift_d     = rd_data;
            sda_oe_d    = ~rd_data[7];
            ptr_d       = ptr_inc(ptr_q);
            state_d     = RD_DATA;
          end
        end

        WAIT_STOP: sda_oe_d = 1'b0;

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe        = sda_oe_q;
  assign valid_address = valid_q;
  assign busy          = busy_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign rd_addr       = ptr_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master against i2c_slave_regs, checked against a register
// array / pointer model of the target.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam logic [6:0] SA = 7'h54;
  localparam int N  = 16;
  localparam int PW = $clog2(N);
  localparam int Q  = 5;  // clk cycles per quarter SCL period

  logic          clk = 1'b0;
  logic          reset_n;
  logic          scl_m, sda_m, sda_bus;
  logic          sda_oe, valid_address, busy, wr_en;
  logic [PW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data, rd_data;

  bit [7:0]    host_regs [N];
  bit [7:0]    mdl_regs  [N];
  int unsigned mdl_ptr;
  int unsigned wr_log [$];
  int unsigned va_cnt = 0;
  int unsigned oe_cnt = 0;
  int unsigned total, bad;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = host_regs[rd_addr];

  i2c_slave_regs #(.SLAVE_ADDR(SA), .NUM_REGS(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .scl_i         (scl_m),
    .sda_i         (sda_bus),
    .sda_oe        (sda_oe),
    .valid_address (valid_address),
    .busy          (busy),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  // Host register bank and event recorders.
  always @(posedge clk) begin
    if (wr_en) begin
      wr_log.push_back(int'({wr_addr, wr_data}));
      host_regs[wr_addr] <= wr_data;
    end
    if (valid_address) va_cnt <= va_cnt + 1;
    if (sda_oe)        oe_cnt <= oe_cnt + 1;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    sda_m = b;  wait_q();
    scl_m = 1'b1; wait_q();
    s = sda_bus; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic start_c();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
    xfer_bit(1'b1, ack);
  endtask

  task automatic write_txn(input int unsigned p, input int unsigned n);
    int unsigned va0, wb;
    int unsigned exp_wr [$];
    logic        ack;
    logic [7:0]  d;
    bit          ok;
    va0 = va_cnt; wb = wr_log.size(); ok = (p < N);
    start_c();
    write_byte({SA, 1'b0}, ack); check_eq("w_addr_ack", ack, 0);
    write_byte(8'(p), ack);      check_eq("w_ptr_ack", ack, ok ? 0 : 1);
    if (ok) mdl_ptr = p;
    for (int unsigned i = 0; i < n; i++) begin
      d = 8'($urandom);
      write_byte(d, ack);
      check_eq("w_data_ack", ack, ok ? 0 : 1);
      if (ok) begin
        exp_wr.push_back((mdl_ptr << 8) | d);
        mdl_regs[mdl_ptr] = d;
        mdl_ptr = (mdl_ptr + 1) % N;
      end
    end
    check_eq("w_busy_before_stop", busy, 1);
    stop_c();
    check_eq("w_busy_after_stop", busy, 0);
    check_eq("w_valid_pulses", va_cnt - va0, 1);
    check_eq("w_wr_count", wr_log.size() - wb, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && (wb + i) < wr_log.size(); i++)
      check_eq("w_addr_data", wr_log[wb + i], exp_wr[i]);
    check_eq("w_ptr_after", rd_addr, mdl_ptr);
  endtask

  // comb=1: write pointer p, repeated START, then read; comb=0: read from current pointer.
  task automatic read_txn(input bit comb, input int unsigned p, input int unsigned n);
    int unsigned va0, wb;
    logic        ack, s;
    logic [7:0]  b, exp;
    va0 = va_cnt; wb = wr_log.size();
    if (comb) begin
      start_c();
      write_byte({SA, 1'b0}, ack); check_eq("r_waddr_ack", ack, 0);
      write_byte(8'(p), ack);      check_eq("r_ptr_ack", ack, 0);
      mdl_ptr = p;
    end
    start_c();
    write_byte({SA, 1'b1}, ack); check_eq("r_addr_ack", ack, 0);
    for (int unsigned i = 0; i < n; i++) begin
      exp = mdl_regs[mdl_ptr];
      mdl_ptr = (mdl_ptr + 1) % N;
      for (int k = 7; k >= 0; k--) begin
        xfer_bit(1'b1, s);
        b[k] = s;
        if (k == 7) check_eq("r_rd_addr_after_load", rd_addr, mdl_ptr);
      end
      xfer_bit((i == n - 1) ? 1'b1 : 1'b0, s);
      check_eq("r_byte", b, exp);
    end
    check_eq("r_busy_after_nack", busy, 0);
    stop_c();
    check_eq("r_valid_pulses", va_cnt - va0, comb ? 2 : 1);
    check_eq("r_no_wr", wr_log.size() - wb, 0);
    check_eq("r_ptr_after", rd_addr, mdl_ptr);
  endtask

  task automatic mismatch_txn(input logic [7:0] abyte);
    int unsigned va0, wb, oe0;
    logic        ack;
    va0 = va_cnt; wb = wr_log.size(); oe0 = oe_cnt;
    start_c();
    write_byte(abyte, ack);           check_eq("m_addr_nack", ack, 1);
    write_byte(8'($urandom), ack);    check_eq("m_byte_nack", ack, 1);
    stop_c();
    check_eq("m_oe_cycles", oe_cnt - oe0, 0);
    check_eq("m_valid_pulses", va_cnt - va0, 0);
    check_eq("m_no_wr", wr_log.size() - wb, 0);
    check_eq("m_busy", busy, 0);
    check_eq("m_ptr", rd_addr, mdl_ptr);
  endtask

  task automatic stopmid_txn(input int unsigned p);
    int unsigned wb;
    logic        ack, s;
    wb = wr_log.size();
    start_c();
    write_byte({SA, 1'b0}, ack); check_eq("s_addr_ack", ack, 0);
    write_byte(8'(p), ack);      check_eq("s_ptr_ack", ack, 0);
    mdl_ptr = p;
    for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), s);
    stop_c();
    check_eq("s_no_wr", wr_log.size() - wb, 0);
    check_eq("s_busy", busy, 0);
    check_eq("s_ptr", rd_addr, mdl_ptr);
    read_txn(1'b0, 0, 1);
  endtask

  task automatic reset_mid_txn();
    logic       ack, s;
    logic [7:0] a;
    a = {SA, 1'b0};
    start_c();
    for (int i = 7; i >= 0; i--) xfer_bit(a[i], s);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    check_eq("x_oe_before_reset", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    check_eq("x_oe_async_release", sda_oe, 0);
    @(negedge clk);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    mdl_ptr = 0;
    check_eq("x_ptr_after_reset", rd_addr, 0);
    check_eq("x_busy_after_reset", busy, 0);
    read_txn(1'b0, 0, 1);
    ack = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ab;
    int unsigned kind;
    total = 0; bad = 0; mdl_ptr = 0;
    reset_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_valid", valid_address, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    write_txn(0, N);          // fill every register, pointer wraps back to 0
    write_txn(3, 2);
    read_txn(1'b1, 15, 2);    // reg 15 then reg 0
    mismatch_txn(8'h50);
    write_txn(16, 2);         // out-of-range pointer
    stopmid_txn(5);

    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: write_txn($urandom_range(0, N - 1), $urandom_range(0, 4));
        1: read_txn(1'b1, $urandom_range(0, N - 1), $urandom_range(1, 4));
        2: read_txn(1'b0, 0, $urandom_range(1, 3));
        3: begin
          do ab = 8'($urandom); while (ab[7:1] == SA);
          mismatch_txn(ab);
        end
        default: write_txn($urandom_range(N, 255), 1);
      endcase
    end

    reset_mid_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
